// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Y86-64 pipeline hazard control, condition codes, halt FSM and
//            saturating stall / mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [2:0]       cf,
    output logic [2:0]       cc,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_halt  = 2'd2;

    localparam logic [3:0] c_reg_none = 4'hF;
    localparam logic [3:0] c_i_mrmovq = 4'h5;
    localparam logic [3:0] c_i_opq    = 4'h6;
    localparam logic [3:0] c_i_jxx    = 4'h7;
    localparam logic [3:0] c_i_ret    = 4'h9;
    localparam logic [3:0] c_i_popq   = 4'hB;

    localparam logic [2:0] c_stat_hlt = 3'd2;
    localparam logic [2:0] c_stat_adr = 3'd3;
    localparam logic [2:0] c_stat_ins = 3'd4;
    localparam logic [2:0] c_cc_reset = 3'b100;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_cc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic w_exc_m;
    logic w_exc_w;
    logic w_load_use;
    logic w_ret_in_pipe;
    logic w_mispred;
    logic w_active;
    logic w_cc_load;

    function automatic logic f_exc(input logic [2:0] s);
        return (s == c_stat_hlt) || (s == c_stat_adr) || (s == c_stat_ins);
    endfunction

    assign w_exc_m       = f_exc(m_stat);
    assign w_exc_w       = f_exc(W_stat);
    assign w_load_use    = ((E_icode == c_i_mrmovq) || (E_icode == c_i_popq)) &&
                           (E_dstM != c_reg_none) &&
                           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_ret_in_pipe = (D_icode == c_i_ret) || (E_icode == c_i_ret) ||
                           (M_icode == c_i_ret);
    assign w_mispred     = (E_icode == c_i_jxx) && !e_cnd;
    assign w_active      = (r_state != c_st_halt);
    assign w_cc_load     = w_active && (E_icode == c_i_opq) && !w_exc_m && !w_exc_w;

    // Pipeline register controls; DRAIN shares the RUN equations.
    always_comb begin
        F_stall     = w_load_use || w_ret_in_pipe;
        D_stall     = w_load_use;
        D_bubble    = w_mispred || (!w_load_use && w_ret_in_pipe);
        E_bubble    = w_mispred || w_load_use;
        M_bubble    = w_exc_m || w_exc_w;
        W_stall     = w_exc_w;
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (w_exc_w) begin
                    w_state_nxt = c_st_halt;
                end else if (w_exc_m) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_exc_w) begin
                    w_state_nxt = c_st_halt;
                end
            end
            c_st_halt: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: begin
                w_state_nxt = c_st_run;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_run;
            r_cc          <= c_cc_reset;
            r_stall_cnt   <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cc_load) begin
                r_cc <= cf;
            end
            if (w_active && F_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_active && w_mispred && (r_mispred_cnt != c_cnt_max)) begin
                r_mispred_cnt <= r_mispred_cnt + c_cnt_one;
            end
        end
    end

    assign cc          = r_cc;
    assign halted      = (r_state == c_st_halt);
    assign stall_cnt   = r_stall_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl: vector table, directed
//            multi-cycle sequences and randomized run against a rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic             e_cnd;
    logic [2:0]       m_stat, W_stat, cf;
    logic [2:0]       cc;
    logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, mispred_cnt;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .cf(cf),
        .cc(cc), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .halted(halted), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] d_ic, sa, sb, e_ic, e_dm;
        logic       cnd;
        logic [3:0] m_ic;
        logic [2:0] ms, ws;
        logic [5:0] exp;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    } vec_t;

    vec_t vecs[18];

    // Behavioural model state
    bit         mdl_halted;
    logic [2:0] mdl_cc;
    int         mdl_stall, mdl_mis;

    function automatic logic [5:0] ctl();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 1'b1;
        M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1; cf = 3'b000;
    endtask

    task automatic apply(input vec_t v);
        D_icode = v.d_ic; d_srcA = v.sa; d_srcB = v.sb;
        E_icode = v.e_ic; E_dstM = v.e_dm; e_cnd = v.cnd;
        M_icode = v.m_ic; m_stat = v.ms; W_stat = v.ws; cf = 3'b000;
    endtask

    // ---- reference model: rule-level evaluation of the control behaviour ----
    function automatic bit is_exc(input logic [2:0] s);
        return s inside {3'd2, 3'd3, 3'd4};
    endfunction

    function automatic logic [5:0] mdl_ctl();
        bit lu, rp, mp;
        lu = (E_icode inside {4'h5, 4'hB}) && E_dstM != 4'hF &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
        rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mp = (E_icode == 4'h7) && !e_cnd;
        if (mdl_halted) return 6'b110111;
        return {lu || rp, lu, mp || (rp && !lu), mp || lu,
                is_exc(m_stat) || is_exc(W_stat), is_exc(W_stat)};
    endfunction

    task automatic mdl_reset();
        mdl_halted = 0; mdl_cc = 3'b100; mdl_stall = 0; mdl_mis = 0;
    endtask

    task automatic mdl_step();
        logic [5:0] c;
        c = mdl_ctl();
        if (!mdl_halted) begin
            if (c[5]) mdl_stall = (mdl_stall < MAXC) ? mdl_stall + 1 : MAXC;
            if (E_icode == 4'h7 && !e_cnd) mdl_mis = (mdl_mis < MAXC) ? mdl_mis + 1 : MAXC;
            if (E_icode == 4'h6 && !is_exc(m_stat) && !is_exc(W_stat)) mdl_cc = cf;
            if (is_exc(W_stat)) mdl_halted = 1;
        end
    endtask

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    function automatic logic [3:0] rand_icode();
        logic [3:0] pool[7];
        pool = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
        return pool[$urandom_range(0, 6)];
    endfunction

    function automatic logic [2:0] rand_stat();
        return ($urandom_range(0, 29) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
    endfunction

    initial begin
        vecs[0]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000};
        vecs[1]  = '{4'h1, 4'hF, 4'h3, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 6'b110100};
        vecs[2]  = '{4'h1, 4'hF, 4'h3, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000};
        vecs[3]  = '{4'h1, 4'h4, 4'hF, 4'hB, 4'h4, 1'b1, 4'h1, 3'd1, 3'd1, 6'b110100};
        vecs[4]  = '{4'h1, 4'hF, 4'h3, 4'h6, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000};
        vecs[5]  = '{4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b101000};
        vecs[6]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd1, 3'd1, 6'b101000};
        vecs[7]  = '{4'h9, 4'h2, 4'hF, 4'h5, 4'h2, 1'b1, 4'h1, 3'd1, 3'd1, 6'b110100};
        vecs[8]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 6'b001100};
        vecs[9]  = '{4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 6'b101100};
        vecs[10] = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000};
        vecs[11] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1, 6'b000010};
        vecs[12] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd4, 6'b000011};
        vecs[13] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd2, 3'd1, 6'b000010};
        vecs[14] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd0, 3'd0, 6'b000000};
        vecs[15] = '{4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000};
        vecs[16] = '{4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b101000};
        vecs[17] = '{4'h1, 4'h3, 4'hF, 4'h2, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000};

        set_idle();
        #12;
        rst_n = 1'b1;
        chk("rst_cc", 16'(cc), 16'h4);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_stall_cnt", 16'(stall_cnt), 16'h0);
        chk("rst_mispred_cnt", 16'(mispred_cnt), 16'h0);
        chk("rst_ctl", 16'(ctl()), 16'h0);

        // Combinational vector table, each vector from a fresh RUN state
        foreach (vecs[i]) begin
            edge1();
            pulse_reset();
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctl", i), 16'(ctl()), 16'(vecs[i].exp));
        end

        // CC load, then hold across a following jXX
        edge1(); pulse_reset(); set_idle();
        E_icode = 4'h6; cf = 3'b011;
        #1 chk("cc_before_edge", 16'(cc), 16'h4);
        edge1();
        chk("cc_load", 16'(cc), 16'h3);
        E_icode = 4'h7; e_cnd = 1'b1; cf = 3'b101;
        #1 chk("jxx_taken_ctl", 16'(ctl()), 16'h0);
        edge1();
        chk("cc_hold_jxx", 16'(cc), 16'h3);

        // CC suppressed by memory-stage exception
        edge1(); pulse_reset(); set_idle();
        E_icode = 4'h6; cf = 3'b011; m_stat = 3'd3;
        #1 chk("supp_ctl", 16'(ctl()), 16'b000010);
        edge1();
        chk("cc_supp", 16'(cc), 16'h4);
        chk("supp_not_halted", 16'(halted), 16'h0);

        // Three mispredicts
        edge1(); pulse_reset(); set_idle();
        E_icode = 4'h7; e_cnd = 1'b0;
        #1 chk("mispred_ctl", 16'(ctl()), 16'b001100);
        repeat (3) edge1();
        chk("mispred_cnt3", 16'(mispred_cnt), 16'd3);
        chk("mispred_no_stall", 16'(stall_cnt), 16'd0);

        // Halt sequence through DRAIN
        edge1(); pulse_reset(); set_idle();
        D_icode = 4'h9;
        repeat (2) edge1();
        D_icode = 4'h1; E_icode = 4'h7; e_cnd = 1'b0;
        edge1();
        set_idle(); m_stat = 3'd2;
        #1 chk("drain_entry_ctl", 16'(ctl()), 16'b000010);
        chk("pre_halt_stall_cnt", 16'(stall_cnt), 16'd2);
        chk("pre_halt_mispred_cnt", 16'(mispred_cnt), 16'd1);
        edge1();
        chk("drain_not_halted", 16'(halted), 16'h0);
        m_stat = 3'd1; W_stat = 3'd2;
        #1 chk("drain_wstall_ctl", 16'(ctl()), 16'b000011);
        edge1();
        chk("halt_entered", 16'(halted), 16'h1);
        set_idle();
        #1 chk("halt_ctl", 16'(ctl()), 16'b110111);
        E_icode = 4'h6; cf = 3'b010; D_icode = 4'h9;
        repeat (2) edge1();
        chk("halt_cc_frozen", 16'(cc), 16'h4);
        chk("halt_stall_frozen", 16'(stall_cnt), 16'd2);
        chk("halt_mispred_frozen", 16'(mispred_cnt), 16'd1);
        chk("halt_sticky", 16'(halted), 16'h1);

        // Asynchronous reset mid-cycle while halted
        #2 rst_n = 1'b0;
        #1;
        chk("arst_halted", 16'(halted), 16'h0);
        chk("arst_cc", 16'(cc), 16'h4);
        chk("arst_stall_cnt", 16'(stall_cnt), 16'd0);
        chk("arst_mispred_cnt", 16'(mispred_cnt), 16'd0);
        chk("arst_ctl", 16'(ctl()), 16'b101000);
        rst_n = 1'b1;

        // Saturation of both counters
        edge1(); pulse_reset(); set_idle();
        D_icode = 4'h9; E_icode = 4'h7; e_cnd = 1'b0;
        repeat (20) edge1();
        chk("sat_stall_cnt", 16'(stall_cnt), 16'(MAXC));
        chk("sat_mispred_cnt", 16'(mispred_cnt), 16'(MAXC));

        // RUN straight to HALT when both statuses are exceptional
        edge1(); pulse_reset(); set_idle();
        m_stat = 3'd2; W_stat = 3'd2;
        edge1();
        chk("direct_halt", 16'(halted), 16'h1);

        // Randomized run against the rule model
        edge1(); pulse_reset(); mdl_reset();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                pulse_reset();
                mdl_reset();
            end
            D_icode = rand_icode(); E_icode = rand_icode(); M_icode = rand_icode();
            d_srcA = rand_reg(); d_srcB = rand_reg(); E_dstM = rand_reg();
            e_cnd = 1'($urandom_range(0, 1));
            m_stat = rand_stat(); W_stat = rand_stat();
            cf = 3'($urandom_range(0, 7));
            #1;
            chk($sformatf("rnd%0d_ctl", n), 16'(ctl()), 16'(mdl_ctl()));
            chk($sformatf("rnd%0d_cc", n), 16'(cc), 16'(mdl_cc));
            chk($sformatf("rnd%0d_halted", n), 16'(halted), 16'(mdl_halted));
            chk($sformatf("rnd%0d_stall_cnt", n), 16'(stall_cnt), 16'(mdl_stall));
            chk($sformatf("rnd%0d_mispred_cnt", n), 16'(mispred_cnt), 16'(mdl_mis));
            @(posedge clk);
            mdl_step();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core, alongside the execute stage. It decides stall and bubble for the F/D/E/M/W pipeline registers each cycle and owns the architectural condition-code register that the execute stage writes and the branch-condition logic reads. It also runs a halt state machine that drains the pipe on an exception status, and keeps saturating performance counters for stalls and mispredicts.

## Interface
- Parameters:
- CNT_W, 16, width of each performance counter
- Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- D_icode  in  4  icode in decode
- d_srcA, d_srcB  in  4 each  decode source registers; 4'hF = none
- E_icode  in  4  icode in execute
- E_dstM  in  4  execute load destination; 4'hF = none
- e_cnd  in  1  branch/cmov condition computed in execute
- M_icode  in  4  icode in memory
- m_stat, W_stat  in  3 each  status codes: BUB=0, AOK=1, HLT=2, ADR=3, INS=4
- cf  in  3  ALU flags {ZF,SF,OF} for the current execute op
- cc  out  3  registered condition codes {ZF,SF,OF}
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline register controls
- halted  out  1  high in HALT state
- stall_cnt, mispred_cnt  out  CNT_W each  saturating event counters

## Operation
- Icodes: 2 cmov, 5 mrmovq, 6 OPq, 7 jXX, 9 ret, B popq.
- exc(s) = s ∈ {HLT, ADR, INS}.
- load_use = E_icode ∈ {5,B} && E_dstM ≠ 4'hF && (E_dstM == d_srcA || E_dstM == d_srcB).
- ret_in_pipe = 9 ∈ {D_icode, E_icode, M_icode}.
- mispred = E_icode == 7 && !e_cnd.
- RUN state, combinational outputs:
  - F_stall = load_use || ret_in_pipe
  - D_stall = load_use
  - D_bubble = mispred || (!load_use && ret_in_pipe)
  - E_bubble = mispred || load_use
  - M_bubble = exc(m_stat) || exc(W_stat)
  - W_stall = exc(W_stat)
- CC register:
  - Loads cf on a clock edge when E_icode == 6, !exc(m_stat) and !exc(W_stat).
  - Otherwise holds.
  - In HALT it never loads.
- State machine, 2-bit encoding RUN=0, DRAIN=1, HALT=2:
  - RUN → DRAIN when exc(m_stat).
  - RUN → HALT directly when exc(W_stat). This case has priority.
  - DRAIN → HALT when exc(W_stat).
  - DRAIN keeps the RUN output equations.
  - HALT is sticky until rst_n is asserted.
  - In HALT: F_stall = D_stall = W_stall = 1, E_bubble = M_bubble = 1, D_bubble = 0.
- Counters:
  - stall_cnt increments on each clock edge in RUN/DRAIN when F_stall = 1.
  - mispred_cnt increments on each clock edge in RUN/DRAIN when mispred = 1.
  - Both saturate at all-ones and do not wrap.
  - Neither increments in HALT.

## Timing
- Reset (asynchronous, immediate): state = RUN, cc = 3'b100 (ZF=1, SF=0, OF=0), stall_cnt = mispred_cnt = 0, halted = 0.
- All stall/bubble outputs are combinational from the current inputs and state. Zero-cycle latency.
- cc changes one edge after the qualifying OPq is in execute. A back-to-back OPq→jXX therefore sees the new flags in the following cycle.
- halted rises one edge after the transition condition is present.
- Simultaneous load_use and ret_in_pipe:
  - F_stall = 1, D_stall = 1, D_bubble = 0, E_bubble = 1.
  - Load-use wins; D_stall and D_bubble are never both 1.
- Simultaneous mispred and ret_in_pipe (ret in D only): D_bubble = 1, E_bubble = 1, F_stall = 1.
- Reset asserted mid-operation: all state clears immediately; counters restart from 0.

## Test plan
- Load-use: E_icode=5, E_dstM=3, d_srcB=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Same stimulus with E_dstM=F → all four 0.
- Mispredict: E_icode=7, e_cnd=0 → D_bubble=1, E_bubble=1. After 3 such cycles mispred_cnt=3.
- CC update and suppression:
  - E_icode=6, cf=3'b011, AOK statuses → cc=3'b011 next edge.
  - Same stimulus with m_stat=ADR → cc holds 3'b100 and M_bubble=1.
- Halt sequence:
  - m_stat=HLT → DRAIN.
  - Next cycle W_stat=HLT → W_stall=1, then HALT with halted=1 and all stalls set.
  - Further cf/OPq stimulus leaves cc unchanged.
- Saturation: with CNT_W=4, hold ret_in_pipe for 20 cycles → stall_cnt=15.
- Async reset: assert rst_n=0 while in HALT with nonzero counters → immediately state=RUN, cc=3'b100, counters 0, halted=0.
